soc_system_pio_in_edge: RTL and testbench



---
 rtl/soc_system_pio_pkg.sv | 16 +
 rtl/soc_system_pio_debounce.sv | 80 ++++++++
 rtl/soc_system_pio_in_edge.sv | 135 +++++++++++++
 tb/tb_soc_system_pio_in_edge.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_system_pio_pkg.sv
// Shared definitions for the edge-capturing PIO input port: register
// addresses and edge capture mode encodings.
package soc_system_pio_pkg;

    typedef enum logic [1:0] {
        ADDR_DATA    = 2'd0,
        ADDR_RSVD    = 2'd1,
        ADDR_IRQMASK = 2'd2,
        ADDR_EDGECAP = 2'd3
    } reg_addr_e;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/soc_system_pio_debounce.sv
// Input conditioning: multi-flop synchroniser followed by an optional
// tick-sampled two-sample debounce filter.
module soc_system_pio_debounce #(
    parameter int WIDTH           = 32,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] filt_o,
    output logic             tick_o
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_s;

    // Shift the asynchronous inputs through the synchroniser chain.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= in_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
        assign filt_o = sync_s;
        assign tick_o = 1'b0;
    end else begin : g_filter
        localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

        logic [CW-1:0]    presc_q, presc_d;
        logic [WIDTH-1:0] smp_q, smp_d;
        logic [WIDTH-1:0] filt_q, filt_d;
        logic [WIDTH-1:0] agree;
        logic             tick;

        // The prescaler wraps at DEBOUNCE_CYCLES-1; that wrap is the sample tick.
        assign tick  = (presc_q == CW'(DEBOUNCE_CYCLES - 1));
        // A bit is accepted only when this tick's sample matches the previous one.
        assign agree = ~(sync_s ^ smp_q);

        // Next-state for prescaler, sample register and filtered value.
        always_comb begin
            presc_d = presc_q + CW'(1);
            smp_d   = smp_q;
            filt_d  = filt_q;
            if (tick) begin
                presc_d = '0;
                smp_d   = sync_s;
                filt_d  = (filt_q & ~agree) | (sync_s & agree);
            end
        end

        // Debounce state registers.
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                presc_q <= '0;
                smp_q   <= '0;
                filt_q  <= '0;
            end else begin
                presc_q <= presc_d;
                smp_q   <= smp_d;
                filt_q  <= filt_d;
            end
        end

        assign filt_o = filt_q;
        assign tick_o = tick;
    end

endmodule

// File: rtl/soc_system_pio_in_edge.sv
// Avalon-MM input PIO with per-bit edge capture, interrupt mask and a
// level IRQ. Inputs are synchronised (and optionally debounced) before
// edge detection; a warm-up counter suppresses edges out of reset.
module soc_system_pio_in_edge
    import soc_system_pio_pkg::*;
#(
    parameter int          WIDTH           = 32,
    parameter int          SYNC_STAGES     = 2,
    parameter int          EDGE_TYPE       = 0,
    parameter int          DEBOUNCE_CYCLES = 0,
    parameter logic [31:0] RESET_MASK      = 32'h0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             write_n,
    input  logic             chipselect,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    // Bypass mode arms once the synchroniser and prev register hold real
    // input; debounce mode arms one clock after the second tick so the first
    // accepted filter value is already in prev.
    localparam int WARM_TARGET = (DEBOUNCE_CYCLES == 0) ? SYNC_STAGES : 2;

    logic [WIDTH-1:0] filt;
    logic             tick;

    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] rise, fall, ev;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] ec_q, ec_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [31:0]      rd_q, rd_d;
    logic             irq_q, irq_d;
    logic [2:0]       warm_q, warm_d;
    logic             armed_q, armed_d;
    logic             warm_step;
    logic             wr_en;
    reg_addr_e        addr;

    soc_system_pio_debounce #(
        .WIDTH           (WIDTH),
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .in_i      (in_port),
        .filt_o    (filt),
        .tick_o    (tick)
    );

    assign addr      = reg_addr_e'(address);
    assign wr_en     = chipselect & ~write_n;
    assign warm_step = (DEBOUNCE_CYCLES == 0) ? 1'b1 : tick;
    assign rise      = filt & ~prev_q;
    assign fall      = ~filt & prev_q;

    // Warm-up counter; armed latches once the target is reached.
    always_comb begin
        warm_d  = warm_q;
        armed_d = armed_q;
        if (!armed_q) begin
            if (warm_q == 3'(WARM_TARGET)) begin
                armed_d = 1'b1;
            end else if (warm_step) begin
                warm_d = warm_q + 3'd1;
            end
        end
    end

    // Select the edge events for the configured mode, gated by arming.
    always_comb begin
        ev = '0;
        if (armed_q) begin
            case (EDGE_TYPE)
                EDGE_RISE: ev = rise;
                EDGE_FALL: ev = fall;
                default:   ev = rise | fall;
            endcase
        end
    end

    // Register file next-state: mask writes, write-1-to-clear capture
    // (a new event in the same clock wins), IRQ and read mux.
    always_comb begin
        mask_d = mask_q;
        clr    = '0;
        if (wr_en && addr == ADDR_IRQMASK) begin
            mask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && addr == ADDR_EDGECAP) begin
            clr = writedata[WIDTH-1:0];
        end
        ec_d  = (ec_q & ~clr) | ev;
        irq_d = |(ec_q & mask_q);

        rd_d = '0;
        case (addr)
            ADDR_DATA:    rd_d[WIDTH-1:0] = filt;
            ADDR_IRQMASK: rd_d[WIDTH-1:0] = mask_q;
            ADDR_EDGECAP: rd_d[WIDTH-1:0] = ec_q;
            default:      rd_d = '0;
        endcase
    end

    // All state registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q  <= '0;
            ec_q    <= '0;
            mask_q  <= RESET_MASK[WIDTH-1:0];
            rd_q    <= '0;
            irq_q   <= 1'b0;
            warm_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            prev_q  <= filt;
            ec_q    <= ec_d;
            mask_q  <= mask_d;
            rd_q    <= rd_d;
            irq_q   <= irq_d;
            warm_q  <= warm_d;
            armed_q <= armed_d;
        end
    end

    assign readdata = rd_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_soc_system_pio_in_edge.sv
`timescale 1ns/1ps
module tb_soc_system_pio_in_edge;

    localparam int NDUT = 3;

    logic clk;
    logic reset_n;
    logic [NDUT-1:0][1:0]  addr_a;
    logic [NDUT-1:0]       wrn_a, cs_a, irq_a;
    logic [NDUT-1:0][31:0] wd_a, inp_a, rd_a;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Three configurations: bypass/rising, debounced/any-edge, bypass/falling.
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int W  = (g == 0) ? 32 : (g == 1) ? 8 : 16;
        localparam int S  = (g == 0) ? 2 : (g == 1) ? 3 : 4;
        localparam int ET = (g == 0) ? 0 : (g == 1) ? 2 : 1;
        localparam int D  = (g == 1) ? 4 : 0;
        localparam int DD = (D == 0) ? 1 : D;
        localparam logic [31:0] RM = (g == 1) ? 32'h3 : (g == 2) ? 32'h00F0 : 32'h0;
        localparam logic [31:0] WM = (W == 32) ? 32'hFFFF_FFFF : ((32'h1 << W) - 32'h1);
        // first clock edge (counted from reset) at which an edge may be captured
        localparam int A  = (D == 0) ? S + 2 : 2 * D + 2;

        soc_system_pio_in_edge #(
            .WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(ET),
            .DEBOUNCE_CYCLES(D), .RESET_MASK(RM)
        ) u_dut (
            .clk(clk), .reset_n(reset_n),
            .address(addr_a[g]), .write_n(wrn_a[g]), .chipselect(cs_a[g]),
            .writedata(wd_a[g]), .readdata(rd_a[g]),
            .in_port(inp_a[g][W-1:0]), .irq(irq_a[g])
        );

        // Reference model: history of sampled inputs indexed by clock edge.
        logic [31:0] hin[$];
        int          k;
        logic [31:0] f_cur, f_old, psamp, m_mask, m_ec, exp_rd;
        logic [31:0] s_bef, f_new, agree, ev, clr;
        logic        exp_irq, wr;

        initial begin
            forever begin
                @(posedge clk or negedge reset_n);
                if (!reset_n) begin
                    hin.delete();
                    k = 0; f_cur = 0; f_old = 0; psamp = 0;
                    m_mask = RM & WM; m_ec = 0; exp_rd = 0; exp_irq = 0;
                end else begin
                    k++;
                    hin.push_back(inp_a[g] & WM);
                    s_bef = (k - S - 1 >= 0) ? hin[k-S-1] : 32'h0;
                    if (D == 0) begin
                        f_new = (k - S >= 0) ? hin[k-S] : 32'h0;
                    end else if (k % DD == 0) begin
                        agree = ~(s_bef ^ psamp);
                        f_new = (f_cur & ~agree) | (s_bef & agree);
                        psamp = s_bef;
                    end else begin
                        f_new = f_cur;
                    end
                    case (ET)
                        0:       ev = f_cur & ~f_old;
                        1:       ev = ~f_cur & f_old;
                        default: ev = f_cur ^ f_old;
                    endcase
                    if (k < A) ev = 0;
                    case (addr_a[g])
                        2'd0:    exp_rd = f_cur;
                        2'd1:    exp_rd = 0;
                        2'd2:    exp_rd = m_mask;
                        default: exp_rd = m_ec;
                    endcase
                    exp_irq = |(m_ec & m_mask);
                    wr  = cs_a[g] && !wrn_a[g];
                    if (wr && addr_a[g] == 2'd2) m_mask = wd_a[g] & WM;
                    clr = (wr && addr_a[g] == 2'd3) ? (wd_a[g] & WM) : 32'h0;
                    m_ec  = (m_ec & ~clr) | ev;
                    f_old = f_cur;
                    f_cur = f_new;
                end
            end
        end

        // Cycle-by-cycle comparison against the model.
        initial begin
            forever begin
                @(negedge clk);
                if (chk_en) begin
                    tests++;
                    if (rd_a[g] !== exp_rd) begin
                        fails++;
                        $display("FAIL readdata dut%0d edge %0d: got %h expected %h", g, k, rd_a[g], exp_rd);
                    end
                    tests++;
                    if (irq_a[g] !== exp_irq) begin
                        fails++;
                        $display("FAIL irq dut%0d edge %0d: got %b expected %b", g, k, irq_a[g], exp_irq);
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input int i, input logic [1:0] a, input logic [31:0] d);
        addr_a[i] = a; wd_a[i] = d; cs_a[i] = 1'b1; wrn_a[i] = 1'b0;
        @(negedge clk);
        cs_a[i] = 1'b0; wrn_a[i] = 1'b1;
    endtask

    task automatic rd(input int i, input logic [1:0] a, output logic [31:0] v);
        addr_a[i] = a;
        @(negedge clk);
        v = rd_a[i];
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        reset_n = 1'b0;
        addr_a = '0; wrn_a = '1; cs_a = '0; wd_a = '0;
        inp_a = '0;
        inp_a[0] = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        chk_en  = 1;
        reset_n = 1'b1;
        idle(10);

        // inputs high through reset: no spurious capture
        rd(0, 2'd0, v); check("t1_data", v, 32'hFFFF_FFFF);
        rd(0, 2'd3, v); check("t1_edgecap", v, 32'h0);
        check("t1_irq", irq_a[0], 1'b0);

        // rising edge on bit 3 with mask 8
        inp_a[0] = 32'h0; idle(5);
        wr(0, 2'd2, 32'h8);
        rd(0, 2'd3, v); check("t2_no_fall_capture", v, 32'h0);
        addr_a[0] = 2'd3; inp_a[0] = 32'h8;
        idle(3); check("t2_irq_early", irq_a[0], 1'b0);
        idle(1); check("t2_irq", irq_a[0], 1'b1);
        check("t2_edgecap", rd_a[0], 32'h8);
        rd(0, 2'd0, v); check("t2_data", v, 32'h8);

        // clear in the same clock as a new edge: set wins
        inp_a[0] = 32'h0; idle(5);
        rd(0, 2'd3, v); check("t3_held", v, 32'h8);
        inp_a[0] = 32'h8; idle(2);
        wr(0, 2'd3, 32'h8);
        idle(1); check("t3_set_wins", rd_a[0], 32'h8);
        idle(3);
        wr(0, 2'd3, 32'h8);
        check("t3_irq_hold", irq_a[0], 1'b1);
        idle(1); check("t3_irq_drop", irq_a[0], 1'b0);
        check("t3_cleared", rd_a[0], 32'h0);

        // debounce: short glitch rejected, long hold accepted
        inp_a[1][0] = 1'b1; idle(2); inp_a[1][0] = 1'b0; idle(20);
        rd(1, 2'd0, v); check("t4_glitch_data", v, 32'h0);
        rd(1, 2'd3, v); check("t4_glitch_edgecap", v, 32'h0);
        inp_a[1][0] = 1'b1; idle(18);
        rd(1, 2'd0, v); check("t4_hold_data", v, 32'h1);
        rd(1, 2'd3, v); check("t4_hold_edgecap", v, 32'h1);
        check("t4_irq_reset_mask", irq_a[1], 1'b1);

        // width rules and ignored registers
        wr(1, 2'd2, 32'hFFFF_FFFF);
        rd(1, 2'd2, v); check("t5_mask_width", v, 32'h0000_00FF);
        wr(1, 2'd0, 32'hFFFF_FFFF);
        wr(1, 2'd1, 32'hFFFF_FFFF);
        rd(1, 2'd1, v); check("t5_rsvd", v, 32'h0);
        rd(1, 2'd0, v); check("t5_data_unchanged", v, 32'h1);

        // any-edge capture on bit 5, then reset mid-sequence
        wr(1, 2'd3, 32'hFF);
        rd(1, 2'd3, v); check("t6_cleared", v, 32'h0);
        inp_a[1][5] = 1'b1; idle(20);
        rd(1, 2'd3, v); check("t6_rise", v, 32'h20);
        wr(1, 2'd3, 32'h20);
        rd(1, 2'd3, v); check("t6_clear_between", v, 32'h0);
        inp_a[1][5] = 1'b0; idle(20);
        rd(1, 2'd3, v); check("t6_fall", v, 32'h20);
        check("t6_irq_before_reset", irq_a[1], 1'b1);
        inp_a[1][5] = 1'b1; idle(3);
        #2 reset_n = 1'b0;
        #1;
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("t6_reset_rd%0d", i), rd_a[i], 32'h0);
            check($sformatf("t6_reset_irq%0d", i), irq_a[i], 1'b0);
        end
        @(negedge clk); idle(2);
        inp_a[0] = 32'hFFFF_FFFF;
        reset_n = 1'b1;
        idle(12);
        rd(0, 2'd3, v); check("t6_rearm_edgecap", v, 32'h0);
        rd(0, 2'd0, v); check("t6_rearm_data", v, 32'hFFFF_FFFF);
        rd(1, 2'd2, v); check("t6_mask_reset", v, 32'h3);

        // randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NDUT; i++) begin
                if ($urandom_range(0, 5) == 0)
                    inp_a[i] = inp_a[i] ^ (32'h1 << $urandom_range(0, 15));
                cs_a[i]   = ($urandom_range(0, 3) == 0);
                wrn_a[i]  = 1'($urandom_range(0, 1));
                addr_a[i] = 2'($urandom_range(0, 3));
                wd_a[i]   = $urandom;
            end
            if (c == 700) begin
                #2 reset_n = 1'b0;
                #2 reset_n = 1'b1;
            end
            @(negedge clk);
        end
        cs_a = '0; wrn_a = '1;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
